// File: rtl/press_gen_pkg.sv
// Shared state encoding and default timing constants for the press generator.
package press_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } press_state_t;

  localparam int DEF_HIGH_CYCLES = 4;
  localparam int DEF_GAP_CYCLES  = 2;
  localparam int DEF_MAX_PENDING = 3;

endpackage

// File: rtl/press_generator.sv
// Turns single-cycle press pulses into key-like high/gap level waveforms,
// queueing presses that arrive while a waveform is in progress.
module press_generator
  import press_gen_pkg::*;
#(
  parameter int HIGH_CYCLES = DEF_HIGH_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int MAX_PENDING = DEF_MAX_PENDING
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in,
  output logic                             out,
  output logic                             busy,
  output logic [$clog2(MAX_PENDING+1)-1:0] pending,
  output logic                             overflow
);

  localparam int PW   = $clog2(MAX_PENDING + 1);
  localparam int TMAX = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] HIGH_LOAD = TW'(HIGH_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);

  if (HIGH_CYCLES < 1) begin : g_bad_high
    $error("press_generator: HIGH_CYCLES must be >= 1");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("press_generator: GAP_CYCLES must be >= 1");
  end
  if (MAX_PENDING < 1) begin : g_bad_pend
    $error("press_generator: MAX_PENDING must be >= 1");
  end

  press_state_t  state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] pending_q, pending_d;
  logic          overflow_q, overflow_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    pending_d  = pending_q;
    overflow_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in) begin
          state_d = HIGH;
          timer_d = HIGH_LOAD;
        end
      end

      HIGH: begin
        if (in) begin
          if (pending_q < PEND_MAX) pending_d = pending_q + PW'(1);
          else                      overflow_d = 1'b1;
        end
        if (timer_q == '0) begin
          state_d = GAP;
          timer_d = GAP_LOAD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      GAP: begin
        if (timer_q == '0) begin
          // Final gap cycle: a dequeue frees a slot, so a request here is never dropped.
          if (pending_q != '0) begin
            state_d = HIGH;
            timer_d = HIGH_LOAD;
            if (!in) pending_d = pending_q - PW'(1);
          end else if (in) begin
            state_d = HIGH;
            timer_d = HIGH_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - TW'(1);
          if (in) begin
            if (pending_q < PEND_MAX) pending_d = pending_q + PW'(1);
            else                      overflow_d = 1'b1;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        timer_d   = '0;
        pending_d = '0;
      end
    endcase
  end

  assign out      = (state_q == HIGH);
  assign busy     = (state_q != IDLE);
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_press_generator.sv
// Directed bench for press_generator: a schedule-of-start-times model checked
// every cycle, plus hand-computed literal expectations per scenario.
module tb_press_generator;

  localparam int H = 4;
  localparam int G = 2;
  localparam int M = 3;
  localparam int P = H + G;

  logic       clk;
  logic       reset;
  logic       in;
  logic       out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  press_generator #(.HIGH_CYCLES(H), .GAP_CYCLES(G), .MAX_PENDING(M)) dut (
    .clk(clk), .reset(reset), .in(in), .out(out), .busy(busy),
    .pending(pending), .overflow(overflow)
  );

  int total = 0;
  int bad   = 0;

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Model: every accepted press owns a start edge s; out is high for edges
  // s..s+H-1 and busy for s..s+P-1. Presses queue back-to-back at P spacing.
  int ecnt = 0;
  int starts[$];
  int m_out, m_busy, m_pend, m_ovf;

  initial begin
    m_out = 0; m_busy = 0; m_pend = 0; m_ovf = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        starts.delete();
        m_out = 0; m_busy = 0; m_pend = 0; m_ovf = 0;
      end else begin
        int nfut, ns;
        ecnt++;
        m_ovf = 0;
        if (in) begin
          nfut = 0;
          foreach (starts[i]) if (starts[i] > ecnt) nfut++;
          if (nfut < M) begin
            ns = ecnt;
            if (starts.size() > 0 && starts[$] + P > ns) ns = starts[$] + P;
            starts.push_back(ns);
          end else begin
            m_ovf = 1;
          end
        end
        while (starts.size() > 1 && starts[0] + P <= ecnt) void'(starts.pop_front());
        m_out = 0; m_busy = 0; m_pend = 0;
        foreach (starts[i]) begin
          if (starts[i] <= ecnt && ecnt < starts[i] + H) m_out = 1;
          if (starts[i] <= ecnt && ecnt < starts[i] + P) m_busy = 1;
          if (starts[i] > ecnt) m_pend++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("model_out", int'(out), m_out);
        chk("model_busy", int'(busy), m_busy);
        chk("model_pending", int'(pending), m_pend);
        chk("model_overflow", int'(overflow), m_ovf);
      end
    end
  end

  // Press edge detector on out, and overflow pulse counter.
  int rises = 0;
  int ovfs  = 0;
  logic prev_out = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (out && !prev_out) rises++;
      if (overflow) ovfs++;
      prev_out = out;
    end
  end

  task automatic cyc(input logic v);
    @(negedge clk);
    in = v;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0);
  endtask

  int r0, o0;

  initial begin
    reset = 1'b1;
    in    = 1'b0;
    #100;
    chk("rst_out", int'(out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_overflow", int'(overflow), 0);
    #150 reset = 1'b0;
    idle(2);

    // Single press
    r0 = rises; o0 = ovfs;
    cyc(1'b1); cyc(1'b0);
    chk("s1_out_k", int'(out), 1);
    chk("s1_pend_k", int'(pending), 0);
    idle(3);
    chk("s1_out_k3", int'(out), 1);
    idle(1);
    chk("s1_out_k4", int'(out), 0);
    chk("s1_busy_k4", int'(busy), 1);
    idle(2);
    chk("s1_busy_k6", int'(busy), 0);
    chk("s1_rises", rises - r0, 1);
    chk("s1_ovf", ovfs - o0, 0);

    // Two consecutive presses
    r0 = rises;
    cyc(1'b1); cyc(1'b1); cyc(1'b0);
    chk("s2_pend", int'(pending), 1);
    idle(20);
    chk("s2_rises", rises - r0, 2);
    chk("s2_busy_end", int'(busy), 0);
    chk("s2_pend_end", int'(pending), 0);

    // Five consecutive presses: queue fills, fifth dropped
    r0 = rises; o0 = ovfs;
    cyc(1'b1); cyc(1'b1); cyc(1'b1); cyc(1'b1);
    chk("s3_pend2", int'(pending), 2);
    cyc(1'b1);
    chk("s3_pend3", int'(pending), 3);
    cyc(1'b0);
    chk("s3_pend_drop", int'(pending), 3);
    chk("s3_ovf_hi", int'(overflow), 1);
    cyc(1'b0);
    chk("s3_ovf_lo", int'(overflow), 0);
    idle(30);
    chk("s3_rises", rises - r0, 4);
    chk("s3_ovf_cnt", ovfs - o0, 1);
    chk("s3_busy_end", int'(busy), 0);

    // Press on the final gap cycle re-enters HIGH directly
    r0 = rises;
    cyc(1'b1);
    idle(5);
    cyc(1'b1);
    chk("s4_out_gap", int'(out), 0);
    chk("s4_busy_gap", int'(busy), 1);
    cyc(1'b0);
    chk("s4_out_re", int'(out), 1);
    chk("s4_pend_re", int'(pending), 0);
    idle(12);
    chk("s4_rises", rises - r0, 2);

    // Fill queue, then asynchronous reset mid-HIGH
    cyc(1'b1); cyc(1'b1); cyc(1'b1); cyc(1'b1); cyc(1'b0);
    chk("s5_pend_full", int'(pending), 3);
    chk("s5_out_pre", int'(out), 1);
    #10 reset = 1'b1;
    #10;
    chk("s5_out_rst", int'(out), 0);
    chk("s5_busy_rst", int'(busy), 0);
    chk("s5_pend_rst", int'(pending), 0);
    chk("s5_ovf_rst", int'(overflow), 0);
    r0 = rises;
    @(negedge clk); @(negedge clk);
    #10 reset = 1'b0;
    idle(20);
    chk("s5_rises_after", rises - r0, 0);
    chk("s5_busy_after", int'(busy), 0);

    // Loopback: random spaced pulses through the edge detector
    r0 = rises; o0 = ovfs;
    for (int n = 0; n < 20; n++) begin
      cyc(1'b1);
      idle($urandom_range(0, 7));
    end
    idle(40);
    chk("s6_loopback", rises - r0, 20 - (ovfs - o0));
    chk("s6_busy_end", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/press_generator.md
# press_generator

Converts single-cycle press pulses back into key-like level waveforms: each accepted pulse produces one "press" (output high for HIGH_CYCLES) followed by a mandatory release gap (output low for GAP_CYCLES). Presses arriving while a waveform is in progress are counted and replayed back-to-back. It sits between pulse-producing logic (game/AI control, test stimulus) and any consumer that expects a physical-key-style level, such as the press edge detector feeding the flap logic. Every accepted pulse therefore appears downstream as exactly one rising edge.

## Interface
Parameters:
- HIGH_CYCLES, 4, cycles `out` is held high per press; must be ≥1.
- GAP_CYCLES, 2, cycles `out` is held low between presses; must be ≥1.
- MAX_PENDING, 3, maximum queued presses; must be ≥1.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in  input  1  press request pulse, sampled each posedge; each high cycle is one request.
- out  output  1  registered key-like level.
- busy  output  1  high whenever state ≠ IDLE.
- pending  output  $clog2(MAX_PENDING+1)  queued presses not yet started.
- overflow  output  1  registered one-cycle pulse: a request was dropped because the queue was full.

## Operation
- States (shared enum): IDLE, HIGH, GAP. Down-counter `timer`, width $clog2(max(HIGH_CYCLES,GAP_CYCLES)), counts remaining cycles in HIGH/GAP.
- Outputs: `out = (state == HIGH)`; `busy = (state != IDLE)`. Both are decoded from registered state only, never from `in`.
- IDLE, in=1: go to HIGH, timer ← HIGH_CYCLES−1. `pending` stays 0.
- IDLE, in=0: stay in IDLE.
- HIGH: decrement timer. When timer==0, go to GAP, timer ← GAP_CYCLES−1.
- GAP: decrement timer. When timer==0, apply the first matching rule:
  - pending>0: go to HIGH, pending−1 (+1 if in=1).
  - in=1: go to HIGH; pending unchanged.
  - otherwise: go to IDLE.
- in=1 while in HIGH, or in GAP before its final cycle: pending+1 if pending<MAX_PENDING; otherwise pending unchanged and overflow=1 for the next cycle.
- When pending==MAX_PENDING on the final GAP cycle with in=1, the decrement frees a slot, so the request is accepted and there is no overflow.
- Invariant: pending==0 whenever state==IDLE.
- Reset (asynchronous, any time, including mid-HIGH): state=IDLE, timer=0, pending=0, out=0, busy=0, overflow=0. In-flight and queued presses are discarded.

## Timing
- Pulse sampled at posedge k from IDLE: out=1 after edge k through edge k+HIGH_CYCLES, then low for GAP_CYCLES. busy falls after edge k+HIGH_CYCLES+GAP_CYCLES if nothing is queued.
- Latency from `in` sampled to `out` rising: one edge (out changes at the sampling edge).
- Back-to-back presses: the high windows are separated by exactly GAP_CYCLES low cycles, with no IDLE cycle inserted.
- Throughput: one press per HIGH_CYCLES+GAP_CYCLES cycles.
- overflow asserts the cycle after the dropped request's sampling edge and lasts one cycle.

## Structure
- Package press_gen_pkg holds:
  - typedef enum press_state_t {IDLE, HIGH, GAP};
  - default parameter constants.
- Single module. No sub-module: the timer and queue counter are too small to split.
- Elaboration-time assertions check HIGH_CYCLES≥1, GAP_CYCLES≥1 and MAX_PENDING≥1.

## Test plan
All scenarios use default parameters (4/2/3), clock period 100.
- Release reset, then one pulse at edge 2 → out high edges 2–6, low edges 6–8, busy drops at edge 8, pending stays 0, overflow never asserts.
- Pulses at edges 2 and 3 → pending=1 after edge 3. Two high windows of 4 cycles separated by exactly 2 low cycles. Then IDLE with pending=0.
- Pulses on 5 consecutive edges starting at edge 2 → pending counts 1, 2, 3. The 5th request is dropped and overflow pulses exactly once. Exactly 4 high windows follow.
- Single pulse, plus a second pulse on the final GAP cycle with pending=0 → HIGH re-entered directly, no IDLE cycle, pending stays 0.
- Fill the queue (pending=3), assert reset asynchronously mid-HIGH between edges → out, busy and pending go to 0 before the next edge. No output after reset is released.
- Loopback: feed out into a press edge detector and drive 20 random pulses with random spacing. Detector pulse count must equal 20 minus the number of overflow pulses.
